// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the display path.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    localparam int unsigned DIGIT_W = 4;

    // The seven-segment decoder renders this code as all segments off.
    localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;
    localparam logic [DIGIT_W-1:0] BCD_NINE  = 4'h9;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the next shift.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIGIT_W'(5)) begin
            dout = din + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one shift per clock; bcd updates only on completion.
// Optional BIN2BCD_LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 27,
    parameter int unsigned DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      overflow
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d, bin_shift;
    logic [BCD_W-1:0]   scr_q, scr_d, scr_adj, scr_shift, fmt;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               ovf_q, ovf_d;
    logic               carry;
    logic               ovf_final;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scr_q[g*DIGIT_W +: DIGIT_W]),
            .dout (scr_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // A bit leaving the top digit means the value needs more digits than we have.
    assign {carry, scr_shift, bin_shift} = {scr_adj, bin_q, 1'b0};
    assign ovf_final = ovf_pend_q | carry;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    logic lead;

    always_comb begin
        fmt  = scr_shift;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (scr_shift[i*DIGIT_W +: DIGIT_W] == '0)) begin
                fmt[i*DIGIT_W +: DIGIT_W] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign fmt = scr_shift;
`endif

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    bin_d      = bin;
                    scr_d      = '0;
                    cnt_d      = CNT_W'(BIN_W - 1);
                    ovf_pend_d = 1'b0;
                    state_d    = StShift;
                end else begin
                    state_d    = StIdle;
                end
            end
            StShift: begin
                busy       = 1'b1;
                bin_d      = bin_shift;
                scr_d      = scr_shift;
                ovf_pend_d = ovf_final;
                if (cnt_q == '0) begin
                    // Result is presented together with the done cycle.
                    state_d = StDone;
                    bcd_d   = ovf_final ? {DIGITS{BCD_NINE}} : fmt;
                    ovf_d   = ovf_final;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed and random conversions against a decimal model.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 27;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned LAT    = BIN_W;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] prev_bcd = '0;
    logic        prev_ovf = 1'b0;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        if (v > 64'd99999999) return 32'h99999999;
        x = v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
        for (int i = 7; i > 0; i--) begin
            if (r[i*4 +: 4] != 4'h0) break;
            r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for done with a bound; returns edges counted from the acceptance edge.
    task automatic wait_done(input int start_edges, output int edges, output int busy_n);
        edges  = start_edges;
        busy_n = 0;
        while (!done && edges < 40) begin
            if (busy) busy_n++;
            if (edges == 13) begin
                check("hold_bcd", 64'(bcd), 64'(prev_bcd));
                check("hold_ovf", 64'(overflow), 64'(prev_ovf));
            end
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic conv(input logic [BIN_W-1:0] v);
        int edges;
        int busy_n;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        wait_done(0, edges, busy_n);
        check("latency", 64'(edges), 64'(LAT));
        check("busy_cycles", 64'(busy_n), 64'(LAT));
        check("bcd", 64'(bcd), 64'(model(64'(v))));
        check("overflow", 64'(overflow), 64'(v > 27'd99999999));
        prev_bcd = model(64'(v));
        prev_ovf = (v > 27'd99999999);
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        int edges;
        int busy_n;
        int dones;
        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        conv(27'd0);
        conv(27'd12345678);
        conv(27'd99999999);
        conv(27'd100000000);
        conv(27'd42);

        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) conv(BIN_W'($urandom_range(134217727, 100000000)));
            else            conv(BIN_W'($urandom_range(99999999, 0)));
        end

        // Start re-pulsed during SHIFT must be ignored.
        @(negedge clk);
        bin   = 27'd555;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bin   = 27'd777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6, edges, busy_n);
        check("ign_latency", 64'(edges), 64'(LAT));
        check("ign_bcd", 64'(bcd), 64'(model(555)));
        // Back-to-back: start presented during the done cycle.
        bin   = 27'd777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done_low", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        prev_bcd = model(555);
        prev_ovf = 1'b0;
        wait_done(0, edges, busy_n);
        check("b2b_latency", 64'(edges), 64'(LAT));
        check("b2b_bcd", 64'(bcd), 64'(model(777)));
        check("b2b_ovf", 64'(overflow), 64'd0);
        prev_bcd = model(777);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        bin   = 27'd123456;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_bcd", 64'(bcd), 64'd0);
        check("arst_ovf", 64'(overflow), 64'd0);
        #2;
        reset = 1'b1;
        dones = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("arst_no_done", 64'(dones), 64'd0);
        prev_bcd = '0;
        prev_ovf = 1'b0;
        conv(27'd9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Iterative shift-add-3 (double-dabble) converter: binary value in, packed BCD digits out.
- Sits directly upstream of the 8-digit seven-segment time multiplexer; its bcd output is the digit bus the multiplexer scans.
- Shows lift counters (floor number, trip count) on the display.
- One shift per clock; the output register updates only on completion, so the display never shows partial results.

Parameters:
- BIN_W, 27, width of binary input (2^27-1 covers 99,999,999).
- DIGITS, 8, number of BCD digits produced; matches the display digit count.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request conversion of bin; sampled on rising clk.
- bin  input  BIN_W  binary value, captured in the cycle start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd/overflow update.
- bcd  output  4*DIGITS  packed result, digit 0 (least significant) in bits [3:0].
- overflow  output  1  high if the last accepted bin exceeded 10^DIGITS-1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, bcd=0, overflow=0, all internal shift/count registers cleared.
- Reset mid-conversion aborts the conversion; no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: capture bin into the shift register, clear the BCD scratch, set bit counter=BIN_W-1, go to SHIFT, busy=1 next cycle.
- SHIFT, each cycle:
  - add 3 to every scratch digit >=5;
  - shift {scratch, binreg} left one bit;
  - any 1 shifted out of the top digit sets the sticky ovf_pend flag.
  - When counter=0 after the shift, go to DONE; otherwise decrement the counter.
  - Exactly BIN_W SHIFT cycles.
- DONE (one cycle):
  - done=1, busy=0;
  - bcd <= scratch, or all 9s (0x99999999 for DIGITS=8) if ovf_pend;
  - overflow <= ovf_pend.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back conversions); otherwise return to IDLE.
- Latency: start accepted at edge N -> done high during cycle N+BIN_W+1 (edge 28 after start for defaults).
- start while in SHIFT is ignored; bin changes during SHIFT are ignored.
- bcd and overflow hold their previous values from acceptance until done.
- Input 0 is legal and yields all-zero digits.
- Overflow is sticky only until the next done; a non-overflowing conversion clears it.

Optional Feature:
- Macro: BIN2BCD_LEADING_ZERO_BLANK_EN.
- Defined: when bcd is loaded in DONE, every zero digit above the most significant non-zero digit is replaced by 4'hF, the blank code that the multiplexer's decoder renders as all segments off. Digit 0 is never blanked. The saturated overflow value is unaffected.
- Undefined: leading zeros are output as 4'h0; no blank codes ever appear.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/SHIFT/DONE);
  - DIGIT_W=4;
  - BCD_BLANK=4'hF;
  - BCD_NINE=4'h9.
- The multiplexer's decoder uses the same BCD_BLANK constant.
- One sub-module, bcd_add3: combinational 4-bit digit correction (in>=5 ? in+3 : in), instanced DIGITS times inside a generate loop.

Test Plan:
- bin=0, pulse start -> done at edge 28 after start, bcd=0x00000000, overflow=0 (with EN: 0xFFFFFFF0).
- bin=12345678 -> bcd=0x12345678, overflow=0; busy high for exactly 27 cycles.
- bin=99999999 -> bcd=0x99999999, overflow=0. Then bin=100000000 -> bcd=0x99999999, overflow=1. Then bin=42 -> bcd=0x00000042 (EN: 0xFFFFFF42), overflow=0.
- Start bin=555, re-pulse start with bin=777 mid-SHIFT -> result 0x00000555 only, a single done pulse; start held high in DONE with bin=777 -> second done 28 cycles later, bcd=0x00000777.
- Pull reset low for 3 ns asynchronously (between clock edges) at shift 10 of a conversion -> busy/done/bcd/overflow immediately 0, no done pulse. After reset release, a new conversion of 9 yields 0x00000009.
